fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, which is the PC and instruction-memory address width.
REQ-002 The block SHALL have parameter INSTR_W, default 16, which is the instruction word width.
REQ-003 The block SHALL have parameter RESET_PC, default 0, which is the PC value loaded on reset.
REQ-004 The block SHALL have parameter PC_STEP, default 1, which is the sequential PC increment.
REQ-005 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-006 Port reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-007 Port stall  input  1  SHALL, when high, hold the PC and the fetch/decode register.
REQ-008 Port flush  input  1  SHALL, when high, kill every in-flight and registered instruction.
REQ-009 Port redirect_valid  input  1  SHALL be the branch/jump request.
REQ-010 Port redirect_addr  input  ADDR_W  SHALL be the branch/jump target.
REQ-011 Port imem_addr  output  ADDR_W  SHALL drive the synchronous instruction ROM address.
REQ-012 Port imem_rdata  input  INSTR_W  SHALL be the ROM data, valid 1 cycle after its address.
REQ-013 Port fd_valid  output  1  SHALL indicate that fd_instr/fd_pc hold a live instruction.
REQ-014 Port fd_instr  output  INSTR_W  SHALL be the instruction presented to decode.
REQ-015 Port fd_pc  output  ADDR_W  SHALL be the address of fd_instr.

Function
REQ-016 State: pc, rsp_valid/rsp_pc (request issued last cycle), buf_valid/buf_instr (stall skid buffer), and fd_valid/fd_instr/fd_pc.
REQ-017 imem_addr SHALL equal pc combinationally.
REQ-018 PC next-value priority: redirect_valid -> redirect_addr; else stall -> hold; else pc+PC_STEP, truncated modulo 2^ADDR_W.
REQ-019 With no stall, flush or redirect: rsp_valid<=1, rsp_pc<=pc; fd<= {rsp_valid, buf_valid ? buf_instr : imem_rdata, rsp_pc}; buf_valid<=0.
REQ-020 On the first stall cycle (stall=1, buf_valid=0, rsp_valid=1): buf_instr<=imem_rdata and buf_valid<=1; rsp and fd SHALL hold.
REQ-021 During further stall cycles, buf, rsp and fd SHALL hold.
REQ-022 On stall release, fd SHALL take buf_instr; the ROM keeps pc, so the next cycle's imem_rdata is valid for the new rsp_pc.
REQ-023 flush or redirect_valid SHALL clear fd_valid, rsp_valid and buf_valid on the next edge, regardless of stall; fd_instr/fd_pc may keep stale values.
REQ-024 When flush=1 and redirect_valid=0, the PC SHALL follow REQ-018, i.e. hold if stalled, else increment.
REQ-025 Latency: an address issued at edge N SHALL appear at fd with fd_valid=1 after edge N+2 when unstalled and unflushed.
REQ-026 Throughput SHALL be one instruction per cycle while stall=0.
REQ-027 Instruction order SHALL be preserved, with no duplicates or drops across any stall/flush/redirect sequence.
REQ-028 Redirect together with stall in the same cycle: the redirect wins; the PC loads the target and in-flight instructions are killed.

Reset
REQ-029 While reset=0: pc=RESET_PC, rsp_valid=0, rsp_pc=0, buf_valid=0, buf_instr=0, fd_valid=0, fd_instr=0, fd_pc=0.
REQ-030 Reset assertion mid-stall or mid-redirect SHALL immediately force the REQ-029 values; there is no pending-state carry-over.
REQ-031 After reset deassertion, the first edge SHALL issue RESET_PC and the second edge SHALL present fd_valid=1, fd_pc=RESET_PC.

Verification
REQ-032 Reset release with ROM[i]=0xA000+i, defaults -> fd_pc 0,1,2,... on consecutive cycles, fd_instr=0xA000+fd_pc.
REQ-033 stall held 3 cycles while fd_pc=4 -> fd holds 4/0xA004 for 3 cycles, then 5,6 follow with no gap, duplicate or loss.
REQ-034 redirect_valid with redirect_addr=0x0040 while fd_pc=7 -> fd_valid=0 for 2 cycles, then fd_pc=0x40, fd_instr=0xA040.
REQ-035 flush for 1 cycle, no redirect -> fd_valid=0 for 2 cycles; PC continues sequentially; the killed addresses never appear.
REQ-036 ADDR_W=8, RESET_PC=0xFE, PC_STEP=1 -> fd_pc sequence 0xFE, 0xFF, 0x00 (wrap).
REQ-037 reset pulsed low during stall with buf_valid=1 -> all outputs 0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: pipeline control in, instruction ROM port, fetch/decode out.
interface fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic               stall;
  logic               flush;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_addr;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               fd_valid;
  logic [INSTR_W-1:0] fd_instr;
  logic [ADDR_W-1:0]  fd_pc;

  // fetch unit side
  modport master (
    input  stall, flush, redirect_valid, redirect_addr, imem_rdata,
    output imem_addr, fd_valid, fd_instr, fd_pc
  );

  // pipeline / ROM environment side
  modport slave (
    output stall, flush, redirect_valid, redirect_addr, imem_rdata,
    input  imem_addr, fd_valid, fd_instr, fd_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-cycle synchronous ROM response tracking,
// stall skid buffer and the fetch/decode register.
module fetch_unit #(
  parameter int ADDR_W   = 16,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0,
  parameter int PC_STEP  = 1
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0]  pc_q,        pc_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0]  rsp_pc_q,    rsp_pc_d;
  logic               buf_valid_q, buf_valid_d;
  logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;
  logic               fd_valid_q,  fd_valid_d;
  logic [INSTR_W-1:0] fd_instr_q,  fd_instr_d;
  logic [ADDR_W-1:0]  fd_pc_q,     fd_pc_d;

  logic kill;
  assign kill = bus.flush | bus.redirect_valid;

  // The ROM always sees the current PC; while stalled it keeps re-reading the
  // same address, so its data is fresh for the new response on release.
  assign bus.imem_addr = pc_q;
  assign bus.fd_valid  = fd_valid_q;
  assign bus.fd_instr  = fd_instr_q;
  assign bus.fd_pc     = fd_pc_q;

  // Next-state: PC priority redirect > stall > increment; kill beats stall
  always_comb begin
    pc_d        = pc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_pc_d    = rsp_pc_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    fd_valid_d  = fd_valid_q;
    fd_instr_d  = fd_instr_q;
    fd_pc_d     = fd_pc_q;

    if (bus.redirect_valid)  pc_d = bus.redirect_addr;
    else if (!bus.stall)     pc_d = pc_q + PC_INC;

    if (kill) begin
      // data/pc fields left stale; only the valids matter
      rsp_valid_d = 1'b0;
      buf_valid_d = 1'b0;
      fd_valid_d  = 1'b0;
    end else if (bus.stall) begin
      // capture the response once; it would be lost as the ROM re-reads pc
      if (rsp_valid_q && !buf_valid_q) begin
        buf_valid_d = 1'b1;
        buf_instr_d = bus.imem_rdata;
      end
    end else begin
      rsp_valid_d = 1'b1;
      rsp_pc_d    = pc_q;
      fd_valid_d  = rsp_valid_q;
      fd_instr_d  = buf_valid_q ? buf_instr_q : bus.imem_rdata;
      fd_pc_d     = rsp_pc_q;
      buf_valid_d = 1'b0;
    end
  end

  // State registers, asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= PC_RST;
      rsp_valid_q <= 1'b0;
      rsp_pc_q    <= '0;
      buf_valid_q <= 1'b0;
      buf_instr_q <= '0;
      fd_valid_q  <= 1'b0;
      fd_instr_q  <= '0;
      fd_pc_q     <= '0;
    end else begin
      pc_q        <= pc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_pc_q    <= rsp_pc_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      fd_valid_q  <= fd_valid_d;
      fd_instr_q  <= fd_instr_d;
      fd_pc_q     <= fd_pc_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// stall/flush/redirect traffic against a queue-based reference model.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rst8 = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(16), .INSTR_W(16)) bus ();
  fetch_unit_if #(.ADDR_W(8),  .INSTR_W(16)) bus8 ();

  fetch_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(0), .PC_STEP(1)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'hFE), .PC_STEP(1)) dut8 (
    .clk(clk), .reset(rst8), .bus(bus8));

  // Synchronous ROMs: ROM[i] = 0xA000 + i
  always @(posedge clk) bus.imem_rdata  <= 16'hA000 + bus.imem_addr;
  always @(posedge clk) bus8.imem_rdata <= 16'hA000 + {8'h00, bus8.imem_addr};

  // Reference model: next fetch PC, addresses issued but not yet presented,
  // and the expected decode-side view.
  logic [15:0] m_pc;
  logic [15:0] m_q[$];
  logic        m_v;
  logic [15:0] m_fpc;

  function automatic void model_reset();
    m_pc = 16'h0;
    m_q.delete();
    m_v = 1'b0;
    m_fpc = 16'h0;
  endfunction

  // Drive one cycle's controls, advance one edge, update the model, settle.
  task automatic cyc(input logic s, input logic f, input logic r, input logic [15:0] ra);
    bus.stall = s; bus.flush = f; bus.redirect_valid = r; bus.redirect_addr = ra;
    @(posedge clk);
    if (r || f) begin
      m_q.delete();
      m_v = 1'b0;
      if (r) m_pc = ra;
      else if (!s) m_pc = m_pc + 16'd1;
    end else if (!s) begin
      if (m_q.size() > 0) begin
        m_v = 1'b1;
        m_fpc = m_q.pop_front();
      end else m_v = 1'b0;
      m_q.push_back(m_pc);
      m_pc = m_pc + 16'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    bus.stall = 0; bus.flush = 0; bus.redirect_valid = 0; bus.redirect_addr = '0;
    #1;
    checks++;
    if ({bus.fd_valid, bus.fd_pc, bus.fd_instr, bus.imem_addr} !== 49'h0) begin
      errors++;
      $display("FAIL reset_state: v=%b pc=%h instr=%h addr=%h, want all 0",
               bus.fd_valid, bus.fd_pc, bus.fd_instr, bus.imem_addr);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.fd_valid, bus.fd_pc, bus.fd_instr, bus.imem_addr} !== 49'h0) begin
      errors++;
      $display("FAIL reset_held: v=%b pc=%h instr=%h addr=%h, want all 0",
               bus.fd_valid, bus.fd_pc, bus.fd_instr, bus.imem_addr);
    end
    reset = 1'b1;
    model_reset();
  endtask

  // fd_pc 0,1,2,... after reset release, first valid after the second edge
  task automatic test_sequential();
    for (int i = 1; i <= 6; i++) begin
      cyc(0, 0, 0, 16'h0);
      checks++;
      if (i < 2) begin
        if (bus.fd_valid !== 1'b0) begin
          errors++;
          $display("FAIL seq_latency edge %0d: v=%b, want 0", i, bus.fd_valid);
        end
      end else if (bus.fd_valid !== 1'b1 || bus.fd_pc !== 16'(i - 2) ||
                   bus.fd_instr !== 16'hA000 + 16'(i - 2)) begin
        errors++;
        $display("FAIL seq edge %0d: v=%b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                 i, bus.fd_valid, bus.fd_pc, bus.fd_instr, 16'(i - 2), 16'hA000 + 16'(i - 2));
      end
    end
  endtask

  // Stall 3 cycles while fd_pc=4, then 5 and 6 with no gap
  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 16'h0);
      checks++;
      if (bus.fd_valid !== 1'b1 || bus.fd_pc !== 16'h4 || bus.fd_instr !== 16'hA004) begin
        errors++;
        $display("FAIL stall_hold %0d: v=%b pc=%h instr=%h, want v=1 pc=0004 instr=a004",
                 k, bus.fd_valid, bus.fd_pc, bus.fd_instr);
      end
    end
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 0, 16'h0);
      checks++;
      if (bus.fd_valid !== 1'b1 || bus.fd_pc !== 16'(5 + k) || bus.fd_instr !== 16'hA000 + 16'(5 + k)) begin
        errors++;
        $display("FAIL stall_release %0d: v=%b pc=%h instr=%h, want v=1 pc=%h",
                 k, bus.fd_valid, bus.fd_pc, bus.fd_instr, 16'(5 + k));
      end
    end
  endtask

  // Redirect to 0x40 while fd_pc=7
  task automatic test_redirect();
    cyc(0, 0, 0, 16'h0);
    checks++;
    if (bus.fd_valid !== 1'b1 || bus.fd_pc !== 16'h7) begin
      errors++;
      $display("FAIL redirect_pre: v=%b pc=%h, want v=1 pc=0007", bus.fd_valid, bus.fd_pc);
    end
    cyc(0, 0, 1, 16'h0040);
    checks++;
    if (bus.fd_valid !== 1'b0 || bus.imem_addr !== 16'h0040) begin
      errors++;
      $display("FAIL redirect_kill1: v=%b addr=%h, want v=0 addr=0040", bus.fd_valid, bus.imem_addr);
    end
    cyc(0, 0, 0, 16'h0);
    checks++;
    if (bus.fd_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_kill2: v=%b, want 0", bus.fd_valid);
    end
    cyc(0, 0, 0, 16'h0);
    checks++;
    if (bus.fd_valid !== 1'b1 || bus.fd_pc !== 16'h0040 || bus.fd_instr !== 16'hA040) begin
      errors++;
      $display("FAIL redirect_target: v=%b pc=%h instr=%h, want v=1 pc=0040 instr=a040",
               bus.fd_valid, bus.fd_pc, bus.fd_instr);
    end
  endtask

  // One-cycle flush at fd_pc=0x41: 0x42/0x43 are killed, 0x44 follows
  task automatic test_flush();
    cyc(0, 0, 0, 16'h0);
    cyc(0, 1, 0, 16'h0);
    checks++;
    if (bus.fd_valid !== 1'b0 || bus.imem_addr !== 16'h0044) begin
      errors++;
      $display("FAIL flush_kill1: v=%b addr=%h, want v=0 addr=0044", bus.fd_valid, bus.imem_addr);
    end
    cyc(0, 0, 0, 16'h0);
    checks++;
    if (bus.fd_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_kill2: v=%b, want 0", bus.fd_valid);
    end
    cyc(0, 0, 0, 16'h0);
    checks++;
    if (bus.fd_valid !== 1'b1 || bus.fd_pc !== 16'h0044 || bus.fd_instr !== 16'hA044) begin
      errors++;
      $display("FAIL flush_resume: v=%b pc=%h instr=%h, want v=1 pc=0044 instr=a044",
               bus.fd_valid, bus.fd_pc, bus.fd_instr);
    end
  endtask

  // Redirect and stall in the same cycle: redirect wins
  task automatic test_stall_redirect();
    cyc(1, 0, 1, 16'h0100);
    checks++;
    if (bus.fd_valid !== 1'b0 || bus.imem_addr !== 16'h0100) begin
      errors++;
      $display("FAIL stall_redirect: v=%b addr=%h, want v=0 addr=0100", bus.fd_valid, bus.imem_addr);
    end
    cyc(0, 0, 0, 16'h0);
    cyc(0, 0, 0, 16'h0);
    checks++;
    if (bus.fd_valid !== 1'b1 || bus.fd_pc !== 16'h0100 || bus.fd_instr !== 16'hA100) begin
      errors++;
      $display("FAIL stall_redirect_target: v=%b pc=%h instr=%h, want v=1 pc=0100",
               bus.fd_valid, bus.fd_pc, bus.fd_instr);
    end
  endtask

  // Random control traffic checked every cycle against the model
  task automatic test_random();
    logic s, f, r;
    logic [15:0] ra;
    for (int n = 0; n < 400; n++) begin
      s  = ($urandom_range(0, 99) < 30);
      f  = ($urandom_range(0, 99) < 8);
      r  = ($urandom_range(0, 99) < 8);
      ra = 16'($urandom);
      cyc(s, f, r, ra);
      checks++;
      if (bus.fd_valid !== m_v || bus.imem_addr !== m_pc ||
          (m_v && (bus.fd_pc !== m_fpc || bus.fd_instr !== 16'hA000 + m_fpc))) begin
        errors++;
        $display("FAIL random %0d: v=%b pc=%h instr=%h addr=%h, want v=%b pc=%h instr=%h addr=%h",
                 n, bus.fd_valid, bus.fd_pc, bus.fd_instr, bus.imem_addr,
                 m_v, m_fpc, 16'hA000 + m_fpc, m_pc);
      end
    end
  endtask

  // Reset pulsed mid-cycle while stalled with a buffered instruction
  task automatic test_reset_mid_stall();
    repeat (3) cyc(0, 0, 0, 16'h0);
    cyc(1, 0, 0, 16'h0);
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({bus.fd_valid, bus.fd_pc, bus.fd_instr, bus.imem_addr} !== 49'h0) begin
      errors++;
      $display("FAIL reset_async: v=%b pc=%h instr=%h addr=%h, want all 0",
               bus.fd_valid, bus.fd_pc, bus.fd_instr, bus.imem_addr);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    cyc(0, 0, 0, 16'h0);
    checks++;
    if (bus.fd_valid !== 1'b0 || bus.imem_addr !== 16'h0001) begin
      errors++;
      $display("FAIL reset_restart1: v=%b addr=%h, want v=0 addr=0001", bus.fd_valid, bus.imem_addr);
    end
    cyc(0, 0, 0, 16'h0);
    checks++;
    if (bus.fd_valid !== 1'b1 || bus.fd_pc !== 16'h0 || bus.fd_instr !== 16'hA000) begin
      errors++;
      $display("FAIL reset_restart2: v=%b pc=%h instr=%h, want v=1 pc=0000 instr=a000",
               bus.fd_valid, bus.fd_pc, bus.fd_instr);
    end
  endtask

  // 8-bit PC from 0xFE wraps to 0x00
  task automatic test_wrap();
    logic [7:0] exp_pc[3];
    exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00;
    checks++;
    if (bus8.imem_addr !== 8'hFE || bus8.fd_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_reset: v=%b addr=%h, want v=0 addr=fe", bus8.fd_valid, bus8.imem_addr);
    end
    rst8 = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus8.fd_valid !== 1'b1 || bus8.fd_pc !== exp_pc[k] ||
          bus8.fd_instr !== 16'hA000 + {8'h00, exp_pc[k]}) begin
        errors++;
        $display("FAIL wrap %0d: v=%b pc=%h instr=%h, want v=1 pc=%h",
                 k, bus8.fd_valid, bus8.fd_pc, bus8.fd_instr, exp_pc[k]);
      end
    end
  endtask

  initial begin
    bus8.stall = 0; bus8.flush = 0; bus8.redirect_valid = 0; bus8.redirect_addr = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_flush();
    test_stall_redirect();
    test_random();
    test_reset_mid_stall();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
